// File: rtl/bsg_clk_dly_tune_pkg.sv
// bsg_clk_dly_tune_pkg: shared state encodings, defaults and status layout for the delay-line tuning controller
package bsg_clk_dly_tune_pkg;
   typedef logic [2:0] state_t;
   localparam state_t IDLE_S   = 3'd0;
   localparam state_t APPLY_S  = 3'd1;
   localparam state_t CLEAR_S  = 3'd2;
   localparam state_t COUNT_S  = 3'd3;
   localparam state_t DRAIN_S  = 3'd4;
   localparam state_t SAMPLE_S = 3'd5;
   localparam state_t FINAL_S  = 3'd6;
   localparam int settle_cycles_def_lp = 8;
   typedef struct packed {
      logic        locked;
      logic        busy;
      logic [15:0] count;
   } tune_status_s;
endpackage

// File: rtl/bsg_clk_dly_tune_timer.sv
// bsg_clk_dly_tune_timer: loadable down-counter with zero flag, shared by all timed waits
module bsg_clk_dly_tune_timer #(
   parameter int width_p = 16
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               load_i,
   input  logic [width_p-1:0] val_i,
   output logic               zero_o
);
   logic [width_p-1:0] cnt_q;
   assign zero_o = (cnt_q == '0);
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) cnt_q <= '0;
      else if (load_i) cnt_q <= val_i;
      else if (!zero_o) cnt_q <= cnt_q - 1'b1;
endmodule

// File: rtl/bsg_clk_dly_tune_ctrl.sv
// bsg_clk_dly_tune_ctrl: SAR search of the oscillator code against a target divider count per window
module bsg_clk_dly_tune_ctrl
   import bsg_clk_dly_tune_pkg::*;
#(
   parameter int ctl_width_p     = 5,
   parameter int count_width_p   = 16,
   parameter int window_width_p  = 16,
   parameter int settle_cycles_p = settle_cycles_def_lp
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   input  logic                      start_i,
   input  logic [count_width_p-1:0]  target_i,
   input  logic [count_width_p-1:0]  tol_i,
   input  logic [window_width_p-1:0] window_i,
   input  logic [count_width_p-1:0]  div_count_i,
   output logic [ctl_width_p-1:0]    ctl_o,
   output logic                      ctl_v_o,
   output logic                      div_clear_o,
   output logic                      div_enable_o,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      locked_o,
   output logic [count_width_p-1:0]  count_o
);
   localparam int iw_lp = (ctl_width_p > 1) ? $clog2(ctl_width_p) : 1;
   localparam logic [window_width_p-1:0] settle_ld_lp = window_width_p'(settle_cycles_p - 1);

   state_t                    state_q, state_d;
   logic [ctl_width_p-1:0]    ctl_q, ctl_d;
   logic                      ctl_v_q, ctl_v_d, done_q, done_d, locked_q, locked_d;
   logic                      final_q, final_d, clear_q, enable_q;
   logic [iw_lp-1:0]          idx_q, idx_d;
   logic [count_width_p-1:0]  count_q, count_d, target_q, target_d, tol_q, tol_d;
   logic [window_width_p-1:0] window_q, window_d, load_val;
   logic                      load, zero;

   // higher count means the oscillator is too fast, so the trial bit is dropped
   logic                     over;
   logic [count_width_p:0]   diff;
   logic [ctl_width_p-1:0]   bit_w, kept;
   assign over  = div_count_i > target_q;
   assign diff  = over ? {1'b0, div_count_i} - {1'b0, target_q} : {1'b0, target_q} - {1'b0, div_count_i};
   assign bit_w = ctl_width_p'(1) << idx_q;
   assign kept  = over ? ctl_q & ~bit_w : ctl_q;

   bsg_clk_dly_tune_timer #(.width_p(window_width_p)) timer (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .load_i(load), .val_i(load_val), .zero_o(zero)
   );

   always_comb begin
      state_d = state_q; ctl_d = ctl_q; ctl_v_d = 1'b0; done_d = 1'b0;
      locked_d = locked_q; count_d = count_q; idx_d = idx_q; final_d = final_q;
      target_d = target_q; tol_d = tol_q; window_d = window_q;
      load = 1'b0; load_val = settle_ld_lp;
      case (state_q)
         IDLE_S: if (start_i) begin
            target_d = target_i; tol_d = tol_i; window_d = window_i;
            ctl_d = ctl_width_p'(1) << (ctl_width_p - 1); idx_d = iw_lp'(ctl_width_p - 1);
            final_d = 1'b0; locked_d = 1'b0; ctl_v_d = 1'b1; load = 1'b1; state_d = APPLY_S;
         end
         APPLY_S, FINAL_S: if (zero) begin
            load = 1'b1; state_d = CLEAR_S;
         end
         CLEAR_S: if (zero) begin
            load = 1'b1;
            load_val = (window_q == '0) ? settle_ld_lp : window_q - 1'b1;
            state_d = (window_q == '0) ? DRAIN_S : COUNT_S;
         end
         COUNT_S: if (zero) begin
            load = 1'b1; state_d = DRAIN_S;
         end
         DRAIN_S: if (zero) state_d = SAMPLE_S;
         SAMPLE_S: begin
            count_d = div_count_i;
            if (final_q) begin
               locked_d = diff <= {1'b0, tol_q}; done_d = 1'b1; state_d = IDLE_S;
            end else begin
               ctl_d = (idx_q != '0) ? kept | (bit_w >> 1) : kept;
               idx_d = (idx_q != '0) ? idx_q - 1'b1 : idx_q;
               final_d = (idx_q == '0);
               state_d = (idx_q != '0) ? APPLY_S : FINAL_S;
               ctl_v_d = 1'b1; load = 1'b1;
            end
         end
         default: state_d = IDLE_S;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         state_q <= IDLE_S; ctl_q <= '0; ctl_v_q <= 1'b0; done_q <= 1'b0; locked_q <= 1'b0;
         count_q <= '0; idx_q <= iw_lp'(ctl_width_p - 1); final_q <= 1'b0;
         target_q <= '0; tol_q <= '0; window_q <= '0; clear_q <= 1'b0; enable_q <= 1'b0;
      end else begin
         state_q <= state_d; ctl_q <= ctl_d; ctl_v_q <= ctl_v_d; done_q <= done_d; locked_q <= locked_d;
         count_q <= count_d; idx_q <= idx_d; final_q <= final_d;
         target_q <= target_d; tol_q <= tol_d; window_q <= window_d;
         clear_q <= (state_d == CLEAR_S); enable_q <= (state_d == COUNT_S);
      end

   assign ctl_o        = ctl_q;
   assign ctl_v_o      = ctl_v_q;
   assign div_clear_o  = clear_q;
   assign div_enable_o = enable_q;
   assign busy_o       = (state_q != IDLE_S);
   assign done_o       = done_q;
   assign locked_o     = locked_q;
   assign count_o      = count_q;
endmodule
